qmax_updater: RTL and testbench

Read-compare-write controller that owns the write side of the per-state Q-max BRAM table. It accepts candidate Q values from the learning datapath, reads the stored maximum for that state, and writes the candidate back only if it is strictly larger. Optionally, it clears the table after reset, because the BRAM itself has no reset. It sits between the Q-update pipeline (upstream) and the Q-max table (downstream).

---
 rtl/qlearn_pkg.sv | 21 ++
 rtl/qmax_init_sweeper.sv | 41 ++++
 rtl/qmax_updater.sv | 146 ++++++++++++++
 tb/tb_qmax_updater.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qlearn_pkg.sv
// Shared definitions for the Q-learning Q-max table logic: controller
// state encoding, default table geometry and the signed Q value type.
package qlearn_pkg;

  localparam int DEF_ADDR_WIDTH = 6;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_DEPTH      = 64;

  // Controller states; INIT only exists in builds with the init sweep.
  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_IDLE = 3'd1,
    ST_RD   = 3'd2,
    ST_CMP  = 3'd3,
    ST_WR   = 3'd4
  } qmax_state_e;

  // Signed Q value at the default width.
  typedef logic signed [DEF_DATA_WIDTH-1:0] q_t;

endpackage

// File: rtl/qmax_init_sweeper.sv
// Address generator for the post-reset table clear: counts 0..DEPTH-1 while
// enabled, flags the final address and then latches a done flag so the
// sweep runs exactly once per reset. Only used when QMAX_INIT_SWEEP_EN is set.
module qmax_init_sweeper
  import qlearn_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_last,
  output logic                  o_done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  logic [ADDR_WIDTH-1:0] count_reg;
  logic                  done_reg;

  // Advance one address per enabled cycle; stop for good after the last one.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count_reg <= '0;
      done_reg  <= 1'b0;
    end else if (i_en && !done_reg) begin
      if (count_reg == LAST_ADDR) begin
        done_reg <= 1'b1;
      end else begin
        count_reg <= count_reg + 1'b1;
      end
    end
  end

  assign o_addr = count_reg;
  assign o_last = (count_reg == LAST_ADDR) && !done_reg;
  assign o_done = done_reg;

endmodule

// File: rtl/qmax_updater.sv
// Read-compare-write owner of the Q-max table write port. A request reads the
// stored maximum for its state, compares signed, and writes the candidate
// back only when strictly larger. One request in flight, 4 cycles each.
// Optional feature macro: QMAX_INIT_SWEEP_EN (clear the table after reset).
module qmax_updater
  import qlearn_pkg::*;
#(
  parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int                    DEPTH      = DEF_DEPTH,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [DATA_WIDTH-1:0] i_req_q,
  output logic                  o_done,
  output logic                  o_updated,
  output logic                  o_busy,
  output logic [ADDR_WIDTH-1:0] o_tbl_addr_r,
  output logic [ADDR_WIDTH-1:0] o_tbl_addr_w,
  output logic                  o_tbl_read_en,
  output logic                  o_tbl_write_en,
  output logic [DATA_WIDTH-1:0] o_tbl_data,
  input  logic [DATA_WIDTH-1:0] i_tbl_data
);

`ifdef QMAX_INIT_SWEEP_EN
  localparam qmax_state_e RESET_STATE = ST_INIT;
`else
  localparam qmax_state_e RESET_STATE = ST_IDLE;
`endif

  qmax_state_e           state_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [DATA_WIDTH-1:0] q_reg;
  logic                  in_range_reg;
  logic                  addr_ok;
  logic                  update_ok;

  // Addresses at or beyond DEPTH are accepted but never touch the table.
  assign addr_ok   = ({1'b0, i_req_addr} < (ADDR_WIDTH + 1)'(DEPTH));
  // Strictly-greater signed compare against the registered read data.
  assign update_ok = in_range_reg && ($signed(q_reg) > $signed(i_tbl_data));

`ifdef QMAX_INIT_SWEEP_EN
  logic [ADDR_WIDTH-1:0] sweep_addr;
  logic                  sweep_last;
  logic                  sweep_done;

  qmax_init_sweeper #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_sweeper (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (state_reg == ST_INIT),
    .o_addr (sweep_addr),
    .o_last (sweep_last),
    .o_done (sweep_done)
  );
`else
  // Without the sweep the init value has no consumer.
  logic unused_init;
  assign unused_init = ^INIT_VALUE;
`endif

  // Controller FSM; every output is registered and set one state ahead.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg      <= RESET_STATE;
      addr_reg       <= '0;
      q_reg          <= '0;
      in_range_reg   <= 1'b0;
      o_req_ready    <= 1'b0;
      o_done         <= 1'b0;
      o_updated      <= 1'b0;
      o_busy         <= 1'b1;
      o_tbl_read_en  <= 1'b0;
      o_tbl_write_en <= 1'b0;
      o_tbl_addr_r   <= '0;
      o_tbl_addr_w   <= '0;
      o_tbl_data     <= '0;
    end else begin
      o_done         <= 1'b0;
      o_updated      <= 1'b0;
      o_tbl_read_en  <= 1'b0;
      o_tbl_write_en <= 1'b0;
      case (state_reg)
`ifdef QMAX_INIT_SWEEP_EN
        ST_INIT: begin
          if (!sweep_done) begin
            o_tbl_write_en <= 1'b1;
            o_tbl_addr_w   <= sweep_addr;
            o_tbl_data     <= INIT_VALUE;
          end
          if (sweep_last) begin
            state_reg <= ST_IDLE;
          end
        end
`endif
        ST_IDLE: begin
          if (i_req_valid && o_req_ready) begin
            addr_reg      <= i_req_addr;
            q_reg         <= i_req_q;
            in_range_reg  <= addr_ok;
            o_tbl_read_en <= addr_ok;
            if (addr_ok) begin
              o_tbl_addr_r <= i_req_addr;
            end
            o_req_ready <= 1'b0;
            o_busy      <= 1'b1;
            state_reg   <= ST_RD;
          end else begin
            o_req_ready <= 1'b1;
            o_busy      <= 1'b0;
          end
        end
        ST_RD: begin
          state_reg <= ST_CMP;
        end
        ST_CMP: begin
          o_tbl_write_en <= update_ok;
          if (update_ok) begin
            o_tbl_addr_w <= addr_reg;
            o_tbl_data   <= q_reg;
          end
          o_done    <= 1'b1;
          o_updated <= update_ok;
          state_reg <= ST_WR;
        end
        ST_WR: begin
          o_req_ready <= 1'b1;
          o_busy      <= 1'b0;
          state_reg   <= ST_IDLE;
        end
        default: begin
          state_reg <= RESET_STATE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qmax_updater.sv
// Bench for qmax_updater: two instances (DEPTH 64 and DEPTH 48), each wired
// to its own registered-read Q-max table. Table-driven request vectors plus
// hand-written sequences for init sweep, back-to-back and mid-op reset.
module tb_qmax_updater;
  import qlearn_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Shared request inputs, per-instance valid and reset.
  logic       rst64 = 1'b1, rst48 = 1'b1;
  logic       valid64 = 1'b0, valid48 = 1'b0;
  logic [5:0] req_addr = '0;
  q_t         req_q = '0;

  // Bench-side preset port into either table.
  logic        tb_we64 = 1'b0, tb_we48 = 1'b0;
  logic [5:0]  tb_waddr = '0;
  logic [31:0] tb_wdata = '0;

  logic        rdy64, done64, upd64, busy64, re64, we64;
  logic [5:0]  ar64, aw64;
  logic [31:0] data64, rdata64;
  logic        rdy48, done48, upd48, busy48, re48, we48;
  logic [5:0]  ar48, aw48;
  logic [31:0] data48, rdata48;

  logic [31:0] mem64 [0:63];
  logic [31:0] mem48 [0:63];

  qmax_updater #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .DEPTH(64), .INIT_VALUE(32'd0)) dut64 (
    .i_clk(clk), .i_rst(rst64), .i_req_valid(valid64), .o_req_ready(rdy64),
    .i_req_addr(req_addr), .i_req_q(req_q), .o_done(done64), .o_updated(upd64),
    .o_busy(busy64), .o_tbl_addr_r(ar64), .o_tbl_addr_w(aw64), .o_tbl_read_en(re64),
    .o_tbl_write_en(we64), .o_tbl_data(data64), .i_tbl_data(rdata64)
  );

  qmax_updater #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .DEPTH(48), .INIT_VALUE(32'd0)) dut48 (
    .i_clk(clk), .i_rst(rst48), .i_req_valid(valid48), .o_req_ready(rdy48),
    .i_req_addr(req_addr), .i_req_q(req_q), .o_done(done48), .o_updated(upd48),
    .o_busy(busy48), .o_tbl_addr_r(ar48), .o_tbl_addr_w(aw48), .o_tbl_read_en(re48),
    .o_tbl_write_en(we48), .o_tbl_data(data48), .i_tbl_data(rdata48)
  );

  // Q-max tables: one write port (DUT first, bench preset second), registered read.
  always @(posedge clk) begin
    if (we64) mem64[aw64] <= data64;
    else if (tb_we64) mem64[tb_waddr] <= tb_wdata;
    if (re64) rdata64 <= mem64[ar64];
  end

  always @(posedge clk) begin
    if (we48) mem48[aw48] <= data48;
    else if (tb_we48) mem48[tb_waddr] <= tb_wdata;
    if (re48) rdata48 <= mem48[ar48];
  end

  // Observation mux so one request task serves both instances.
  logic        sel = 1'b0;
  logic        obs_ready, obs_done, obs_upd, obs_re, obs_we;
  logic [5:0]  obs_ar, obs_aw;
  logic [31:0] obs_data;
  assign obs_ready = sel ? rdy48  : rdy64;
  assign obs_done  = sel ? done48 : done64;
  assign obs_upd   = sel ? upd48  : upd64;
  assign obs_re    = sel ? re48   : re64;
  assign obs_we    = sel ? we48   : we64;
  assign obs_ar    = sel ? ar48   : ar64;
  assign obs_aw    = sel ? aw48   : aw64;
  assign obs_data  = sel ? data48 : data64;

  typedef struct {
    bit          s;
    logic [5:0]  addr;
    logic [31:0] q;
    bit          do_pre;
    logic [31:0] pre;
    bit          exp_rd;
    bit          exp_upd;
    logic [31:0] exp_final;
  } vec_t;

  vec_t vecs [0:10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic preset(input bit s, input logic [5:0] a, input logic [31:0] d);
    @(negedge clk);
    tb_waddr = a;
    tb_wdata = d;
    if (s) tb_we48 = 1'b1; else tb_we64 = 1'b1;
    @(negedge clk);
    tb_we48 = 1'b0;
    tb_we64 = 1'b0;
  endtask

  // One request with cycle-exact checks at T+1..T+4 relative to the accept.
  task automatic do_req(input bit s, input logic [5:0] a, input logic [31:0] qv,
                        input bit exp_rd, input bit exp_upd);
    int n;
    sel = s;
    @(negedge clk);
    req_addr = a;
    req_q    = qv;
    if (s) valid48 = 1'b1; else valid64 = 1'b1;
    n = 0;
    while (!obs_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", obs_ready, 1);
    if (!obs_ready) begin
      valid48 = 1'b0;
      valid64 = 1'b0;
      return;
    end
    @(negedge clk);  // T+1
    valid48 = 1'b0;
    valid64 = 1'b0;
    chk("t1_read_en", obs_re, exp_rd);
    if (exp_rd) chk("t1_read_addr", obs_ar, a);
    chk("t1_ready_low", obs_ready, 0);
    chk("t1_write_en", obs_we, 0);
    @(negedge clk);  // T+2
    chk("t2_read_en", obs_re, 0);
    chk("t2_done", obs_done, 0);
    @(negedge clk);  // T+3
    chk("t3_done", obs_done, 1);
    chk("t3_updated", obs_upd, exp_upd);
    chk("t3_write_en", obs_we, exp_upd);
    chk("t3_read_en", obs_re, 0);
    if (exp_upd) begin
      chk("t3_write_addr", obs_aw, a);
      chk("t3_write_data", obs_data, qv);
    end
    @(negedge clk);  // T+4
    chk("t4_ready", obs_ready, 1);
    chk("t4_done", obs_done, 0);
    chk("t4_write_en", obs_we, 0);
    $display("req inst=%0d addr=%0d q=%0d updated=%0b", s ? 48 : 64, a, $signed(qv), obs_upd);
  endtask

  // Starts in the cycle where reset has just been released on dut64; checks
  // the sweep (or its absence), no o_done, and when o_req_ready rises.
  task automatic post_reset(input string tag, output int wr_cnt, output int rdy_idx);
    int bad_addr, bad_data, bad_done;
    bad_addr = 0;
    bad_data = 0;
    bad_done = 0;
    wr_cnt   = 0;
    rdy_idx  = -1;
    chk({tag, "_c0_write_en"}, we64, 0);
    chk({tag, "_c0_ready"}, rdy64, 0);
    chk({tag, "_c0_busy"}, busy64, 1);
    chk({tag, "_c0_done"}, done64, 0);
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (done64) bad_done++;
      if (we64) begin
        if (aw64 !== 6'(wr_cnt)) bad_addr++;
        if (data64 !== 32'd0) bad_data++;
        wr_cnt++;
      end
      if (rdy64) begin
        rdy_idx = n;
        break;
      end
    end
    chk({tag, "_sweep_addr_order"}, bad_addr, 0);
    chk({tag, "_sweep_data"}, bad_data, 0);
    chk({tag, "_no_done"}, bad_done, 0);
`ifdef QMAX_INIT_SWEEP_EN
    chk({tag, "_write_cycles"}, wr_cnt, 64);
    chk({tag, "_ready_cycle"}, rdy_idx, 65);
`else
    chk({tag, "_write_cycles"}, wr_cnt, 0);
    chk({tag, "_ready_cycle"}, rdy_idx, 1);
`endif
    $display("%s: writes=%0d ready_at=%0d", tag, wr_cnt, rdy_idx);
  endtask

  initial begin
    int wr_cnt, rdy_idx, bad, n;
    int acc [0:2];
    logic [5:0]  b2b_addr [0:2];
    logic [31:0] b2b_q    [0:2];

    vecs[0]  = '{0, 6'd5,  32'd25,         1, 32'd10,         1, 1, 32'd25};
    vecs[1]  = '{0, 6'd5,  32'd25,         0, 32'd0,          1, 0, 32'd25};
    vecs[2]  = '{0, 6'd5,  -32'sd3,        0, 32'd0,          1, 0, 32'd25};
    vecs[3]  = '{0, 6'd7,  -32'sd50,       1, -32'sd100,      1, 1, -32'sd50};
    vecs[4]  = '{0, 6'd9,  32'd0,          1, 32'hFFFF_FFFF,  1, 1, 32'd0};
    vecs[5]  = '{0, 6'd10, 32'h8000_0000,  1, 32'd5,          1, 0, 32'd5};
    vecs[6]  = '{0, 6'd63, 32'h7FFF_FFFF,  1, 32'h7FFF_FFFE,  1, 1, 32'h7FFF_FFFF};
    vecs[7]  = '{0, 6'd0,  32'd2,          1, 32'd3,          1, 0, 32'd3};
    vecs[8]  = '{1, 6'd50, 32'd7,          0, 32'd0,          0, 0, 32'd0};
    vecs[9]  = '{1, 6'd48, 32'd100,        0, 32'd0,          0, 0, 32'd0};
    vecs[10] = '{1, 6'd47, 32'd5,          1, 32'd0,          1, 1, 32'd5};

    // Reset values while reset is held.
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", rdy64, 0);
    chk("rst_done", done64, 0);
    chk("rst_updated", upd64, 0);
    chk("rst_busy", busy64, 1);
    chk("rst_read_en", re64, 0);
    chk("rst_write_en", we64, 0);
    chk("rst_addr_r", ar64, 0);
    chk("rst_addr_w", aw64, 0);
    chk("rst_data", data64, 0);
    @(negedge clk);
    rst64 = 1'b0;
    rst48 = 1'b0;
    post_reset("startup", wr_cnt, rdy_idx);

`ifdef QMAX_INIT_SWEEP_EN
    bad = 0;
    for (int i = 0; i < 64; i++) if (mem64[i] !== 32'd0) bad++;
    chk("sweep_readback", bad, 0);
`endif
    n = 0;
    while (!rdy48 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("inst48_ready", rdy48, 1);

    // Table-driven request vectors.
    for (int i = 0; i <= 10; i++) begin
      if (vecs[i].do_pre) preset(vecs[i].s, vecs[i].addr, vecs[i].pre);
      do_req(vecs[i].s, vecs[i].addr, vecs[i].q, vecs[i].exp_rd, vecs[i].exp_upd);
      if (vecs[i].exp_rd)
        chk($sformatf("vec%0d_entry", i),
            vecs[i].s ? mem48[vecs[i].addr] : mem64[vecs[i].addr], vecs[i].exp_final);
    end

    // Back-to-back with valid held high: accepts at T, T+4, T+8.
    preset(0, 6'd1, 32'd0);
    preset(0, 6'd2, 32'd0);
    sel = 1'b0;
    b2b_addr[0] = 6'd1; b2b_q[0] = 32'd4;
    b2b_addr[1] = 6'd2; b2b_q[1] = 32'd9;
    b2b_addr[2] = 6'd1; b2b_q[2] = 32'd6;
    @(negedge clk);
    valid64 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_addr = b2b_addr[k];
      req_q    = b2b_q[k];
      n = 0;
      while (!rdy64 && n < 50) begin
        @(negedge clk);
        n++;
      end
      acc[k] = rdy64 ? cyc : -1000;
      @(negedge clk);
    end
    valid64 = 1'b0;
    chk("b2b_second_accept", acc[1] - acc[0], 4);
    chk("b2b_third_accept", acc[2] - acc[0], 8);
    n = 0;
    while (!rdy64 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_entry1", mem64[1], 32'd6);
    chk("b2b_entry2", mem64[2], 32'd9);
    $display("b2b accepts at %0d %0d %0d", acc[0], acc[1], acc[2]);

    // Reset asserted while the request sits in CMP.
    sel = 1'b0;
    @(negedge clk);
    req_addr = 6'd5;
    req_q    = 32'd1000;
    valid64  = 1'b1;
    n = 0;
    while (!rdy64 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("midrst_accept", rdy64, 1);
    @(negedge clk);  // T+1 (RD)
    valid64 = 1'b0;
    @(negedge clk);  // T+2 (CMP)
    rst64 = 1'b1;
    @(negedge clk);
    rst64 = 1'b0;
    post_reset("midrst", wr_cnt, rdy_idx);
`ifdef QMAX_INIT_SWEEP_EN
    chk("midrst_entry5", mem64[5], 32'd0);
`else
    chk("midrst_entry5", mem64[5], 32'd25);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
